// File: rtl/tpu_pkg.sv
//------------------------------------------------------------------------------
// Module      : tpu_pkg
// Description : Shared opcode/state types and constants for the TPU host bridge.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package tpu_pkg;

    typedef enum logic [1:0] {
        LOAD_W = 2'd0,
        LOAD_A = 2'd1,
        START  = 2'd2,
        READ   = 2'd3
    } tpu_op_e;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        RUN   = 3'd2,
        FETCH = 3'd3,
        CAPT  = 3'd4,
        SEND  = 3'd5
    } host_if_state_e;

    localparam logic [7:0] UIO_OE_MASK = 8'hF0;

    function automatic int acc_bytes(input int acc_w);
        return (acc_w + 7) / 8;
    endfunction

endpackage

`default_nettype wire

// File: rtl/tpu_host_if_if.sv
//------------------------------------------------------------------------------
// Module      : tpu_host_if_if
// Description : Operand-write / start / result-read bus between bridge and core.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface tpu_host_if_if #(
    parameter int N      = 2,
    parameter int DATA_W = 8,
    parameter int ACC_W  = 16
);
    localparam int ADDR_W = (N * N > 1) ? $clog2(N * N) : 1;

    logic              wr_en;
    logic              wr_sel;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              core_start;
    logic              core_done;
    logic [ADDR_W-1:0] rd_addr;
    logic [ACC_W-1:0]  rd_data;

    modport master (
        output wr_en, wr_sel, wr_addr, wr_data, core_start, rd_addr,
        input  core_done, rd_data
    );

    modport slave (
        input  wr_en, wr_sel, wr_addr, wr_data, core_start, rd_addr,
        output core_done, rd_data
    );

endinterface

`default_nettype wire

// File: rtl/tpu_result_serializer.sv
//------------------------------------------------------------------------------
// Module      : tpu_result_serializer
// Description : Loads one accumulator word and emits it LSB byte first (valid/ready).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tpu_result_serializer
    import tpu_pkg::*;
#(
    parameter int ACC_W = 16
) (
    input  wire              clk,
    input  wire              rst_n,
    input  wire              load,
    input  wire [ACC_W-1:0]  load_data,
    input  wire              out_ready,
    output logic             out_valid,
    output logic [7:0]       out_data,
    output logic             out_last
);
    localparam int ACC_BYTES = acc_bytes(ACC_W);
    localparam int SH_W      = ACC_BYTES * 8;
    localparam int CNT_W     = (ACC_BYTES > 1) ? $clog2(ACC_BYTES) : 1;

    logic [SH_W-1:0]  r_shift;
    logic [CNT_W-1:0] r_cnt;
    logic             r_valid;
    logic             w_last;

    assign w_last = (r_cnt == CNT_W'(ACC_BYTES - 1));

    // Shifting in zeros leaves the register clear once the word is drained.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift <= '0;
            r_cnt   <= '0;
            r_valid <= 1'b0;
        end else if (load) begin
            r_shift <= SH_W'(load_data);
            r_cnt   <= '0;
            r_valid <= 1'b1;
        end else if (r_valid && out_ready) begin
            r_shift <= r_shift >> 8;
            if (w_last) begin
                r_valid <= 1'b0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign out_valid = r_valid;
    assign out_data  = r_shift[7:0];
    assign out_last  = w_last;

endmodule

`default_nettype wire

// File: rtl/tpu_host_if.sv
//------------------------------------------------------------------------------
// Module      : tpu_host_if
// Description : Byte-serial Tiny Tapeout host bridge for the systolic TPU core.
//               Optional RUN watchdog enabled by TPU_HOST_IF_TIMEOUT_EN.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tpu_host_if
    import tpu_pkg::*;
#(
    parameter int N           = 2,
    parameter int DATA_W      = 8,
    parameter int ACC_W       = 16,
    parameter int TIMEOUT_CYC = 1024
) (
    input  wire        clk,
    input  wire        rst_n,
    input  wire [7:0]  ui_in,
    input  wire [7:0]  uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe,
    tpu_host_if_if.master core
);
    localparam int NUM_EL = N * N;
    localparam int ADDR_W = (NUM_EL > 1) ? $clog2(NUM_EL) : 1;
    localparam logic [ADDR_W-1:0] c_last_idx = ADDR_W'(NUM_EL - 1);

    host_if_state_e    r_state;
    host_if_state_e    w_state_nxt;
    logic [ADDR_W-1:0] r_idx;
    logic              r_err;
    logic              r_wr_en;
    logic              r_wr_sel;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [DATA_W-1:0] r_wr_data;
    logic              r_core_start;

    logic       w_in_valid;
    logic       w_out_ready;
    logic       w_in_ready;
    logic       w_accept;
    logic       w_cmd_legal;
    tpu_op_e    w_op;
    logic       w_idle_cmd;
    logic       w_load_byte;
    logic       w_ser_valid;
    logic       w_ser_last;
    logic [7:0] w_ser_byte;
    logic       w_ser_fire;
    logic       w_result_done;
    logic       w_timeout;
    logic       w_unused_uio;

    assign w_in_valid    = uio_in[0];
    assign w_out_ready   = uio_in[1];
    assign w_unused_uio  = &{1'b0, uio_in[7:2]};
    assign w_in_ready    = (r_state == IDLE) || (r_state == LOAD);
    assign w_accept      = w_in_valid && w_in_ready;
    assign w_cmd_legal   = (ui_in[7:2] == 6'd0);
    assign w_op          = tpu_op_e'(ui_in[1:0]);
    assign w_idle_cmd    = (r_state == IDLE) && w_accept && w_cmd_legal;
    assign w_load_byte   = (r_state == LOAD) && w_accept;
    assign w_ser_fire    = (r_state == SEND) && w_ser_valid && w_out_ready;
    assign w_result_done = w_ser_fire && w_ser_last;

`ifdef TPU_HOST_IF_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TO_W-1:0] r_to_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_to_cnt <= '0;
        end else if ((r_state == RUN) && !core.core_done) begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
        end else begin
            r_to_cnt <= '0;
        end
    end

    // Fires at the end of the TIMEOUT_CYC-th RUN cycle.
    assign w_timeout = (r_state == RUN) && !core.core_done &&
                       (r_to_cnt == TO_W'(TIMEOUT_CYC - 1));
`else
    assign w_timeout = (TIMEOUT_CYC < 0);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_idle_cmd) begin
                    case (w_op)
                        LOAD_W, LOAD_A: w_state_nxt = LOAD;
                        START:          w_state_nxt = RUN;
                        READ:           w_state_nxt = FETCH;
                        default:        w_state_nxt = IDLE;
                    endcase
                end
            end
            LOAD: begin
                if (w_load_byte && (r_idx == c_last_idx)) begin
                    w_state_nxt = IDLE;
                end
            end
            RUN: begin
                if (core.core_done || w_timeout) begin
                    w_state_nxt = IDLE;
                end
            end
            FETCH: w_state_nxt = CAPT;
            CAPT:  w_state_nxt = SEND;
            SEND: begin
                if (w_result_done) begin
                    w_state_nxt = (r_idx == c_last_idx) ? IDLE : FETCH;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx        <= '0;
            r_err        <= 1'b0;
            r_wr_en      <= 1'b0;
            r_wr_sel     <= 1'b0;
            r_wr_addr    <= '0;
            r_wr_data    <= '0;
            r_core_start <= 1'b0;
        end else begin
            r_wr_en      <= w_load_byte;
            r_core_start <= w_idle_cmd && (w_op == START);

            if (w_load_byte) begin
                r_wr_addr <= r_idx;
                r_wr_data <= DATA_W'(ui_in);
            end

            if (w_idle_cmd && ((w_op == LOAD_W) || (w_op == LOAD_A))) begin
                r_wr_sel <= (w_op == LOAD_A);
            end

            if (w_idle_cmd) begin
                r_idx <= '0;
            end else if (w_load_byte || w_result_done) begin
                r_idx <= (r_idx == c_last_idx) ? '0 : r_idx + ADDR_W'(1);
            end

            // Sticky until the next accepted START.
            if ((r_state == IDLE) && w_accept && !w_cmd_legal) begin
                r_err <= 1'b1;
            end else if (w_idle_cmd && (w_op == START)) begin
                r_err <= 1'b0;
            end else if (w_timeout) begin
                r_err <= 1'b1;
            end
        end
    end

    tpu_result_serializer #(
        .ACC_W (ACC_W)
    ) u_ser (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (r_state == CAPT),
        .load_data (core.rd_data),
        .out_ready (w_out_ready),
        .out_valid (w_ser_valid),
        .out_data  (w_ser_byte),
        .out_last  (w_ser_last)
    );

    assign core.wr_en      = r_wr_en;
    assign core.wr_sel     = r_wr_sel;
    assign core.wr_addr    = r_wr_addr;
    assign core.wr_data    = r_wr_data;
    assign core.core_start = r_core_start;
    assign core.rd_addr    = r_idx;

    assign uo_out  = w_ser_byte;
    assign uio_out = {w_in_ready, w_ser_valid, (r_state != IDLE), r_err, 4'b0000};
    assign uio_oe  = UIO_OE_MASK;

endmodule

`default_nettype wire

// File: doc/tpu_host_if.md
# tpu_host_if

Byte-serial host bridge between the Tiny Tapeout pin interface and the systolic TPU core. It accepts commands and operand bytes on `ui_in`, writes weights and activations into the core, starts a computation, and streams accumulator results back on `uo_out`. A valid/ready handshake on the `uio` pins controls both directions. Array size and accumulator width are parameters.

## Interface
- `N`, 2: array dimension; a matrix is N*N elements, indexed row-major.
- `DATA_W`, 8: operand width; fixed to one byte per element.
- `ACC_W`, 16: accumulator width. `ACC_BYTES = ceil(ACC_W/8)`.
- `TIMEOUT_CYC`, 1024: RUN watchdog limit. Used only with `TPU_HOST_IF_TIMEOUT_EN`.

Ports:
- `clk  in  1`: sole clock, rising edge.
- `rst_n  in  1`: reset, asynchronous, active-low.
- `ui_in  in  8`: command byte or data byte.
- `uio_in  in  8`:
  - [0] in_valid
  - [1] out_ready
  - [7:2] ignored
- `uo_out  out  8`: result byte.
- `uio_out  out  8`:
  - [7] in_ready
  - [6] out_valid
  - [5] busy (state is not IDLE)
  - [4] err
  - [3:0] = 0
- `uio_oe  out  8`: constant 8'hF0.
- `wr_en  out  1`: core operand write strobe.
- `wr_sel  out  1`: 0 selects weight, 1 selects activation.
- `wr_addr  out  $clog2(N*N)`: element index.
- `wr_data  out  DATA_W`: element value.
- `core_start  out  1`: one-cycle start pulse.
- `core_done  in  1`: core completion, level or pulse.
- `rd_addr  out  $clog2(N*N)`: result index.
- `rd_data  in  ACC_W`: result. Read latency is 1 cycle (cycle t+1 shows the data for `rd_addr` of cycle t).

## Operation
- A byte is accepted on a rising edge where in_valid && in_ready.
- Opcodes are taken from `ui_in[1:0]` of a byte accepted in IDLE; `ui_in[7:2]` must be 0.
  - 0 LOAD_W
  - 1 LOAD_A
  - 2 START
  - 3 READ
- A command byte with `ui_in[7:2]` nonzero is dropped, sets err, and the block stays in IDLE.
- States:
  - IDLE: in_ready=1. LOAD_W/LOAD_A go to LOAD with idx=0 and `wr_sel` latched. START goes to RUN. READ goes to FETCH with idx=0, byte=0.
  - LOAD: in_ready=1. Every accepted byte is a data byte, including bytes that look like opcodes. It produces a write of element idx, then idx++. After element N*N-1 the block returns to IDLE.
  - RUN: in_ready=0. Waits for `core_done`=1, then goes to IDLE. A `core_done` that arrives in any other state is ignored.
  - FETCH: `rd_addr`=idx for 1 cycle, then goes to CAPT.
  - CAPT: loads `rd_data` into the output shift register, then goes to SEND.
  - SEND: out_valid=1 and `uo_out` = current byte, least significant byte first. Bits of the top byte above ACC_W are zero.
    - On out_valid && out_ready the block shifts. After ACC_BYTES bytes it increments idx and goes to FETCH.
    - After result N*N-1 it goes to IDLE.
- in_valid is ignored in RUN, FETCH, CAPT and SEND.
- `rd_addr` is held at idx in CAPT and SEND.
- err is sticky. It clears only when a START command is accepted.
- With `uio_in[7:2]` ignored, there is no abort. Only `rst_n` cancels a transfer in progress.

## Timing
- Reset values: state=IDLE, idx=0, and every output is 0 except in_ready=1 and `uio_oe`=8'hF0.
- Write path: accept edge at cycle t, then `wr_en`=1 with registered `wr_addr`/`wr_data` during cycle t+1. `wr_en` is a single cycle per byte, so back-to-back bytes give back-to-back writes.
- START: `core_start`=1 for exactly the cycle after the accept edge.
- READ: out_valid rises 3 cycles after the accept edge.
- Between results there are 2 dead cycles (FETCH, CAPT), during which out_valid=0.
- Within one result, consecutive bytes can transfer on consecutive cycles.
- If out_ready stays low, out_valid and `uo_out` hold steady indefinitely.
- Reset asserted mid-operation: all outputs return to their reset values immediately (asynchronously). Any partial load or read is abandoned.

## Configuration
- `TPU_HOST_IF_TIMEOUT_EN`
  - Defined: a counter of width $clog2(TIMEOUT_CYC+1) runs in RUN. If TIMEOUT_CYC cycles pass without `core_done`, the block goes to IDLE and sets err.
  - Undefined: no counter; RUN waits indefinitely.
- The err path for illegal opcodes exists in both builds.

## Structure
- Package `tpu_pkg` holds:
  - `tpu_op_e` (LOAD_W, LOAD_A, START, READ)
  - `host_if_state_e` (IDLE, LOAD, RUN, FETCH, CAPT, SEND)
  - `UIO_OE_MASK` = 8'hF0
- Sub-module `tpu_result_serializer`: parametrised on ACC_W. It loads an ACC_W word and emits it LSB-first with valid/ready, and flags the last byte.
- The top-level TT wrapper instantiates `tpu_host_if` next to the core.

## Test plan
Configuration N=2, ACC_W=16:
1. Reset: hold `rst_n`=0 → in_ready=1, busy=0, err=0, `uio_oe`=F0, no `wr_en`.
2. Weight load: send 00, 11, 22, 33, 44 → four `wr_en` pulses with `wr_sel`=0, addr 0..3, data 11..44; busy=0 afterwards.
3. Start/done: send 02 → one `core_start` pulse; busy=1 until `core_done`=1; a byte sent during RUN is not accepted.
4. Read with backpressure: results {0x1234, 0x0056, 0xFFFF, 0x0001}, send 03 → bytes 34 12 56 00 FF FF 01 00. While out_ready is toggled, `uo_out` stays stable whenever out_ready=0.
5. Illegal and reset: send 0x84 → err=1 and state stays IDLE; then send 01 followed by two bytes, pulse `rst_n` → IDLE, idx=0, and a fresh LOAD_A writes starting at addr 0.
6. Timeout (macro on): START with `core_done` never asserted → IDLE and err=1 after exactly TIMEOUT_CYC RUN cycles.
